uop_fetch_sequencer: RTL and testbench
======================================

// Module: uop_fetch_sequencer
// PURPOSE
//  Read-side controller for the 64x32 uop cache BRAM (SDP, 1-cycle read latency, no output reg).
//  On a start command, issues a run of sequential reads (base address, length, 6-bit wrap) and
//  delivers each uop on a valid/ready stream to the issue stage. A 2-entry output FIFO absorbs
//  BRAM latency and downstream stalls; one uop/cycle is sustained when ready stays high.
// PARAMETERS
//  ADDR_WIDTH  6   cache address width (64 entries); address arithmetic is modulo 2**ADDR_WIDTH
//  DATA_WIDTH  32  uop width
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  start          in   1   command pulse; accepted only in IDLE
//  base_addr      in   6   first cache address of the run, sampled with start
//  length         in   7   uops in the run, 0..64, sampled with start
//  flush          in   1   synchronous abort: return to IDLE, discard FIFO and in-flight read
//  cache_rd_en    out  1   BRAM read enable
//  cache_rd_addr  out  6   BRAM read address
//  cache_rd_data  in   32  BRAM read data, valid the cycle after cache_rd_en
//  uop_valid      out  1   FIFO head valid
//  uop_data       out  32  FIFO head uop
//  uop_ready      in   1   downstream accept; transfer when uop_valid & uop_ready
//  busy           out  1   high from start acceptance until the last uop transfers
//  done           out  1   1-cycle pulse after the last uop of a run transfers
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, inflight=0, counters 0.
//  States: IDLE -> RUN on start (length!=0); IDLE -> IDLE with done pulse next cycle on start with
//   length==0 (no reads, busy stays 0). RUN -> DRAIN when last read issued. DRAIN -> IDLE when
//   FIFO empty, inflight==0 and last transfer done; done=1 for that one cycle after.
//  start in RUN/DRAIN is ignored; base_addr/length only sampled on accepted start.
//  Issue rule (registered outputs driven combinationally from state): cache_rd_en=1 iff state==RUN
//   and (fifo_count + inflight - pop) < 2, pop = uop_valid & uop_ready this cycle.
//  cache_rd_addr = base_addr + issued_count (mod 64); 63 wraps to 0. issued_count increments per read.
//  inflight (0/1) set on cycle of read, cleared next cycle when cache_rd_data is pushed to FIFO.
//  FIFO push and pop in same cycle allowed at any count; push never occurs when full (issue rule).
//  Latency: start at cycle t -> first read at t+1 -> uop_valid at t+3 (data captured t+2 into FIFO).
//  uop_data stable while uop_valid & ~uop_ready; order matches address order exactly.
//  flush has priority over start and all other events: next cycle state IDLE, FIFO empty,
//   inflight data discarded, cache_rd_en=0, busy=0, no done pulse. start with flush is dropped.
//  reset mid-run: identical to flush plus all counters to 0.
//  busy = (state != IDLE). done never coincides with busy.
// TESTING
//  1 reset; start base=0x05 len=4, ready=1 -> reads 05,06,07,08 on 4 consecutive cycles; 4 uops
//    one per cycle in address order; done pulses once; busy high exactly start+1 .. last transfer.
//  2 base=0x3E len=4 -> addresses 3E,3F,00,01; uop order preserved across wrap.
//  3 len=8, ready toggles 1/0 each cycle -> no dropped/duplicated uops, FIFO never >2,
//    uop_data held while stalled, cache_rd_en deasserts when FIFO+inflight full.
//  4 len=64, ready=1 -> all 64 entries read once, full throughput (64 transfers in 64 cycles).
//  5 len=0 -> no cache_rd_en, uop_valid never set, single done pulse; start during RUN ignored.
//  6 flush (and separately reset) mid-run with read in flight -> next cycle uop_valid=0, busy=0,
//    no done; new start then yields fresh run with no stale uop emitted.

Source files
------------

// File: rtl/uop_fetch_sequencer.sv
// Read-side sequencer for the uop cache: issues a run of sequential BRAM reads and
// streams the returned uops through a 2-entry FIFO onto a valid/ready interface.
module uop_fetch_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  flush,
  output logic                  cache_rd_en,
  output logic [ADDR_WIDTH-1:0] cache_rd_addr,
  input  logic [DATA_WIDTH-1:0] cache_rd_data,
  output logic                  uop_valid,
  output logic [DATA_WIDTH-1:0] uop_data,
  input  logic                  uop_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count_q;
  logic                  done_q, done_d;
  logic                  rd_en;
  logic                  pop, push;
  logic [2:0]            occupancy;

  assign pop  = uop_valid & uop_ready;
  assign push = inflight_q;
  // Slots that will be committed after this cycle's pop; a new read must still fit.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && length != '0) state_d = RUN;
        if (start && length == '0) done_d = 1'b1;
      end
      RUN: begin
        if (occupancy < 3'd2) rd_en = 1'b1;
        if (rd_en && issued_q == len_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave on the cycle the final uop transfers so busy drops right after it.
        if (!inflight_q && count_q == 2'd1 && pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      rd_en   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count_q     <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (flush) begin
        inflight_q <= 1'b0;
        rd_ptr     <= 1'b0;
        wr_ptr     <= 1'b0;
        count_q    <= '0;
      end else begin
        inflight_q <= rd_en;
        if (state_q == IDLE && start) begin
          base_q   <= base_addr;
          len_q    <= length;
          issued_q <= '0;
        end else if (rd_en) begin
          issued_q <= issued_q + 1'b1;
        end
        if (push) begin
          fifo_mem[wr_ptr] <= cache_rd_data;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign cache_rd_en   = rd_en;
  assign cache_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  assign uop_valid     = (count_q != 2'd0);
  assign uop_data      = fifo_mem[rd_ptr];
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_uop_fetch_sequencer.sv
// Directed bench for uop_fetch_sequencer: cycle table for a basic run and a zero-length
// start, then hand sequences for wrap, stalls, full-length runs, flush and reset.
module tb_uop_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic        flush;
  logic        cache_rd_en;
  logic [5:0]  cache_rd_addr;
  logic [31:0] cache_rd_data;
  logic        uop_valid;
  logic [31:0] uop_data;
  logic        uop_ready;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  uop_fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .flush(flush), .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
    .cache_rd_data(cache_rd_data), .uop_valid(uop_valid), .uop_data(uop_data),
    .uop_ready(uop_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] uop_of(input logic [5:0] a);
    return {8'hA5, 2'b00, a, 8'h5A, 2'b11, ~a};
  endfunction

  // BRAM model: one-cycle read latency, no output register.
  always_ff @(posedge clk)
    if (cache_rd_en) cache_rd_data <= uop_of(cache_rd_addr);

  typedef struct {
    logic        start;
    logic [5:0]  base;
    logic [6:0]  len;
    logic        ready;
    logic        exp_rd_en;
    logic [5:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic s, input logic [5:0] b, input logic [6:0] l,
                              input logic en, input logic [5:0] a, input logic v,
                              input logic [31:0] d, input logic bz, input logic dn);
    vec_t r;
    r.start = s; r.base = b; r.len = l; r.ready = 1'b1;
    r.exp_rd_en = en; r.exp_addr = a; r.exp_valid = v; r.exp_data = d;
    r.exp_busy = bz; r.exp_done = dn;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sequence(input logic [5:0] base, input int len, input bit toggle,
                              input bit spurious, input string name);
    int nreads = 0, nxfer = 0, ndone = 0, first = -1, last = -1, gaps = 0;
    bit held = 1'b0, finished = 1'b0;
    logic [31:0] held_data = '0;
    logic [5:0]  a;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      start     = (cyc == 0) || (spurious && cyc == 2);
      base_addr = (cyc == 0) ? base : 6'h00;
      length    = (cyc == 0) ? len[6:0] : 7'd10;
      uop_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (held) begin
        check({name, " held_valid"}, {31'b0, uop_valid}, 32'd1);
        check({name, " held_data"}, uop_data, held_data);
      end
      if (cache_rd_en) begin
        a = base + nreads[5:0];
        check({name, " rd_addr"}, {26'b0, cache_rd_addr}, {26'b0, a});
        nreads++;
      end else if (busy && nreads > 0 && nreads < len) begin
        gaps++;
      end
      if (uop_valid && uop_ready) begin
        a = base + nxfer[5:0];
        check({name, " uop_data"}, uop_data, uop_of(a));
        if (first < 0) first = cyc;
        last = cyc;
        nxfer++;
      end
      held      = uop_valid && !uop_ready;
      held_data = uop_data;
      if (done) begin
        ndone++;
        check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
        finished = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    uop_ready = 1'b1;
    check({name, " finished"}, {31'b0, finished}, 32'd1);
    check({name, " reads"}, nreads, len);
    check({name, " transfers"}, nxfer, len);
    check({name, " done_count"}, ndone, 1);
    if (toggle) check({name, " rd_en_throttled"}, {31'b0, gaps > 0}, 32'd1);
    else begin
      check({name, " rd_gaps"}, gaps, 0);
      check({name, " xfer_span"}, last - first + 1, len);
    end
    @(negedge clk);
    check({name, " done_after"}, {31'b0, done}, 32'd0);
    check({name, " busy_after"}, {31'b0, busy}, 32'd0);
    tick();
  endtask

  // Starts a run at 0x10, aborts it with flush or reset on the cycle a read is in flight.
  task automatic abort_sequence(input bit use_reset, input string name);
    for (int cyc = 0; cyc < 4; cyc++) begin
      start = (cyc == 0); base_addr = 6'h10; length = 7'd8; uop_ready = 1'b1;
      if (cyc == 3) begin
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        start = 1'b1;
      end
      @(negedge clk);
      if (cyc == 3) check({name, " inflight_before"}, {31'b0, uop_valid}, 32'd1);
      tick();
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    @(negedge clk);
    check({name, " valid_after"}, {31'b0, uop_valid}, 32'd0);
    check({name, " busy_after"}, {31'b0, busy}, 32'd0);
    check({name, " rd_en_after"}, {31'b0, cache_rd_en}, 32'd0);
    if (use_reset) check({name, " rd_addr_after"}, {26'b0, cache_rd_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, " no_done"}, {31'b0, done}, 32'd0);
      check({name, " stays_empty"}, {31'b0, uop_valid}, 32'd0);
      tick();
    end
    run_sequence(6'h20, 3, 1'b0, 1'b0, {name, " fresh"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; flush = 1'b0; uop_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("reset rd_en", {31'b0, cache_rd_en}, 32'd0);
    check("reset rd_addr", {26'b0, cache_rd_addr}, 32'd0);
    check("reset valid", {31'b0, uop_valid}, 32'd0);
    check("reset data", uop_data, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    vecs[0]  = mk(1, 6'h05, 7'd4, 0, 6'h00, 0, 32'h0, 0, 0);
    vecs[1]  = mk(0, 6'h00, 7'd0, 1, 6'h05, 0, 32'h0, 1, 0);
    vecs[2]  = mk(0, 6'h00, 7'd0, 1, 6'h06, 0, 32'h0, 1, 0);
    vecs[3]  = mk(0, 6'h00, 7'd0, 1, 6'h07, 1, uop_of(6'h05), 1, 0);
    vecs[4]  = mk(0, 6'h00, 7'd0, 1, 6'h08, 1, uop_of(6'h06), 1, 0);
    vecs[5]  = mk(0, 6'h00, 7'd0, 0, 6'h00, 1, uop_of(6'h07), 1, 0);
    vecs[6]  = mk(0, 6'h00, 7'd0, 0, 6'h00, 1, uop_of(6'h08), 1, 0);
    vecs[7]  = mk(0, 6'h00, 7'd0, 0, 6'h00, 0, 32'h0, 0, 1);
    vecs[8]  = mk(0, 6'h00, 7'd0, 0, 6'h00, 0, 32'h0, 0, 0);
    vecs[9]  = mk(1, 6'h11, 7'd0, 0, 6'h00, 0, 32'h0, 0, 0);
    vecs[10] = mk(0, 6'h00, 7'd0, 0, 6'h00, 0, 32'h0, 0, 1);
    vecs[11] = mk(0, 6'h00, 7'd0, 0, 6'h00, 0, 32'h0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; base_addr = vecs[i].base; length = vecs[i].len;
      uop_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d rd_en", i), {31'b0, cache_rd_en}, {31'b0, vecs[i].exp_rd_en});
      if (vecs[i].exp_rd_en)
        check($sformatf("vec%0d rd_addr", i), {26'b0, cache_rd_addr}, {26'b0, vecs[i].exp_addr});
      check($sformatf("vec%0d valid", i), {31'b0, uop_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d data", i), uop_data, vecs[i].exp_data);
      check($sformatf("vec%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
      check($sformatf("vec%0d done", i), {31'b0, done}, {31'b0, vecs[i].exp_done});
      tick();
    end
    start = 1'b0;

    run_sequence(6'h3E, 4, 1'b0, 1'b0, "wrap");
    run_sequence(6'h08, 8, 1'b1, 1'b0, "stall");
    run_sequence(6'h00, 64, 1'b0, 1'b0, "full64");
    run_sequence(6'h30, 3, 1'b0, 1'b1, "start_in_run");
    abort_sequence(1'b0, "flush");
    abort_sequence(1'b1, "reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
